// File: rtl/drum_step_audio_ctrl.sv
// drum_step_audio_ctrl
// Paces the drum patch-grid solver one step at a time, captures the middle
// node amplitude once a step has settled, scales/saturates it to 16-bit audio
// and queues it in a small FIFO drained by the codec through valid/ready.
// Also drives the solver's rho input.
//
// Optional feature macro: DRUM_RHO_NONLINEAR_EN
//   defined   : rho_out = min(RHO_MAX, rho_base + (mid^2 >>> (17+RHO_SHIFT)))
//               with the nonlinear term refreshed on every capture
//   undefined : rho_out is rho_base delayed by one cycle, no multiplier built

module drum_step_audio_ctrl #(
  parameter int          STEP_CYCLES = 18,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          GAIN_SHIFT  = 0,
  parameter int          RHO_SHIFT   = 4,
  parameter logic [17:0] RHO_MAX     = 18'h04000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          run,
  input  logic [17:0]                   mid_node_out,
  input  logic [17:0]                   rho_base,
  output logic                          solver_enable,
  output logic [17:0]                   rho_out,
  output logic [15:0]                   audio_data,
  output logic                          audio_valid,
  input  logic                          audio_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   step_count
);

  localparam int CW = $clog2(STEP_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int W  = 18 + GAIN_SHIFT;

  // Reject configurations the datapath cannot represent.
  if (STEP_CYCLES < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      GAIN_SHIFT < 0 || GAIN_SHIFT > 7 || RHO_SHIFT < 0 || RHO_SHIFT > 18 ||
      RHO_MAX[17]) begin : g_bad_config
    $error("drum_step_audio_ctrl: unsupported parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE
  } state_t;

  state_t              state;
  logic [CW-1:0]       count;

  logic signed [W-1:0] scaled;
  logic [17:0]         saturated;
  logic [15:0]         sample;

  logic [15:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       rd_next;
  logic                push;
  logic                pop;
  logic                fifo_full;

  assign audio_valid = (fifo_level != '0);
  assign fifo_full   = (fifo_level == LW'(FIFO_DEPTH));
  assign pop         = audio_valid && audio_ready;
  // The start condition reserves a slot, so the full guard never blocks a real capture.
  assign push        = (state == CAPTURE) && (!fifo_full || pop);
  assign rd_next     = rd_ptr + AW'(1);

  // Step sequencer: one step in flight, enable pulse and step counter registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      count         <= '0;
      solver_enable <= 1'b0;
      step_count    <= '0;
    end else begin
      solver_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (run && !fifo_full) begin
            solver_enable <= 1'b1;
            count         <= CW'(STEP_CYCLES - 1);
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (count == '0) begin
            state <= CAPTURE;
          end else begin
            count <= count - CW'(1);
          end
        end
        CAPTURE: begin
          step_count <= step_count + 16'd1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gain shift with saturation to the 18-bit range, then keep the top 16 bits.
  always_comb begin
    scaled    = W'($signed(mid_node_out)) <<< GAIN_SHIFT;
    saturated = scaled[17:0];
    if (!(&scaled[W-1:17]) && (|scaled[W-1:17])) begin
      saturated = scaled[W-1] ? 18'h20000 : 18'h1FFFF;
    end
    sample = 16'(saturated >> 2);
  end

  // Sample storage; contents are only meaningful between the pointers.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= sample;
    end
  end

  // FIFO pointers, occupancy and the head register that drives audio_data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      audio_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      // Head follows the oldest entry; it holds its last value once the FIFO drains.
      if (push && (fifo_level == '0 || (pop && fifo_level == LW'(1)))) begin
        audio_data <= sample;
      end else if (pop && fifo_level >= LW'(2)) begin
        audio_data <= mem[rd_next];
      end
    end
  end

`ifdef DRUM_RHO_NONLINEAR_EN
  logic [17:0]        nl_term;
  logic signed [35:0] product;
  logic signed [18:0] rho_sum;

  assign product = $signed(mid_node_out) * $signed(mid_node_out);
  assign rho_sum = {rho_base[17], rho_base} + {1'b0, nl_term};

  // Nonlinear tension: refresh the amplitude-squared term on capture, clamp the sum.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nl_term <= '0;
      rho_out <= '0;
    end else begin
      if (state == CAPTURE) begin
        nl_term <= 18'(product >>> (17 + RHO_SHIFT));
      end
      if (rho_sum > $signed({1'b0, RHO_MAX})) begin
        rho_out <= RHO_MAX;
      end else begin
        rho_out <= rho_sum[17:0];
      end
    end
  end
`else
  // Linear tension: rho is the base coefficient delayed by one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rho_out <= '0;
    end else begin
      rho_out <= rho_base;
    end
  end
`endif

endmodule

// File: doc/drum_step_audio_ctrl.md
Name: drum_step_audio_ctrl

Overview:
- Sits directly downstream of the drum patch-grid solver.
- Paces the solver one time step at a time with a single-cycle enable pulse, then captures the solver's 18-bit middle-node amplitude once the step settles.
- Scales and saturates the capture to 16-bit audio and buffers it in a small FIFO drained by the audio-codec side through a valid/ready handshake.
- Also drives the solver's rho input.

Parameters:
- STEP_CYCLES, 18: clock cycles the solver needs after an enable pulse before mid_node_out is valid (min 1).
- FIFO_DEPTH, 8: audio sample FIFO depth, power of 2, min 2.
- GAIN_SHIFT, 0: left shift applied to the captured amplitude before saturation (0..7).
- RHO_SHIFT, 4: nonlinear rho scaling shift (used only with the optional feature).
- RHO_MAX, 18'h04000: rho ceiling (used only with the optional feature).

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- run  in  1  level; 1 permits new solver steps.
- mid_node_out  in  18  signed 1.17 middle-node amplitude from the solver.
- rho_base  in  18  signed 1.17 base tension coefficient.
- solver_enable  out  1  one-cycle pulse starting one solver step.
- rho_out  out  18  signed 1.17 rho to the solver.
- audio_data  out  16  signed audio sample at the FIFO head.
- audio_valid  out  1  FIFO non-empty.
- audio_ready  in  1  consumer accepts audio_data when audio_valid && audio_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- step_count  out  16  completed steps, wraps 16'hFFFF -> 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0, FIFO empty, state IDLE, cycle counter 0.
  - Takes effect immediately, including in the middle of a step; any in-flight step is abandoned and nothing is captured.
- States:
  - IDLE: if run && fifo_level < FIFO_DEPTH, assert solver_enable this cycle, load counter with STEP_CYCLES-1, go to WAIT. Otherwise stay in IDLE with solver_enable=0.
  - WAIT: decrement counter each cycle; when the counter is 0, go to CAPTURE. WAIT lasts exactly STEP_CYCLES cycles.
  - CAPTURE: sample mid_node_out, push the scaled value into the FIFO, increment step_count, go to IDLE.
- Step period is STEP_CYCLES+2 cycles while run=1 and the FIFO is not full.
- Only one step is ever in flight. The start condition guarantees a free FIFO slot at CAPTURE, so pushes are never dropped.
- run falling during WAIT or CAPTURE: the in-flight step completes and is captured; no new enable is issued.
- Scaling, combinational on the captured value:
  - Sign-extend to 18+GAIN_SHIFT bits and shift left by GAIN_SHIFT.
  - Saturate to the 18-bit range [18'h20000, 18'h1FFFF].
  - audio = saturated[17:2] (truncate).
- FIFO:
  - Circular buffer; the head register drives audio_data.
  - audio_valid = (fifo_level != 0).
  - Pop on audio_valid && audio_ready.
  - Push and pop in the same cycle: level unchanged, data order preserved.
  - Pop on empty: no effect.
  - audio_data holds its value while audio_valid=0.
  - audio_valid is asserted the cycle after CAPTURE when the FIFO was empty.
- rho_out:
  - Registered.
  - Without the optional feature, rho_out <= rho_base every cycle (1-cycle latency).

Optional Feature:
- Macro: DRUM_RHO_NONLINEAR_EN.
- Defined:
  - In CAPTURE, nl_term <= (mid_node_out * mid_node_out) >>> (17+RHO_SHIFT), using a 36-bit product.
  - Every cycle, rho_out <= min(RHO_MAX, rho_base + nl_term), with the sum computed at 19 bits and clamped.
  - nl_term resets to 0.
- Undefined: no multiplier is built; rho_out follows rho_base as described under Behaviour.

Test Plan:
- Steady stepping: STEP_CYCLES=18, GAIN_SHIFT=0, run=1, audio_ready=1, mid_node_out=18'h08000.
  - solver_enable pulses every 20 cycles.
  - Each capture yields audio_data=16'h2000; audio_valid is high 1 cycle after CAPTURE.
  - step_count increments per step.
- Backpressure: audio_ready=0 with ramp inputs 1..8 captured.
  - fifo_level reaches 8, after which solver_enable stays 0.
  - Raising audio_ready pops 8 samples in order; stepping resumes.
- Saturation: GAIN_SHIFT=2.
  - mid_node_out=18'h10000 -> audio_data=16'h7FFF.
  - mid_node_out=18'h30000 -> audio_data=16'h8000.
  - mid_node_out=18'h00400 -> audio_data=16'h0400.
- run drop: deassert run 5 cycles into WAIT.
  - The step completes; exactly one more sample is pushed; no further solver_enable.
- Mid-step reset: assert reset=0 during WAIT with 3 samples queued.
  - All outputs are 0 in the same cycle; fifo_level=0.
  - After release with run=1, the first enable comes from IDLE.
- DRUM_RHO_NONLINEAR_EN: rho_base=18'h01000, RHO_SHIFT=4.
  - mid_node_out=18'h10000 -> rho_out=18'h01800 after CAPTURE.
  - rho_base=18'h03C00 with the same mid_node_out -> rho_out clamps to 18'h04000.
